// File: rtl/lc3b_types.sv
// lc3b_types: shared predictor types: 2-bit counter states, reset value and saturating step
package lc3b_types;
  typedef enum logic [1:0] {BP_SNT = 2'b00, BP_WNT, BP_WT, BP_ST} bp_ctr_t;
  localparam bp_ctr_t BP_CTR_RESET = BP_WNT;
  function automatic bp_ctr_t bp_ctr_next(bp_ctr_t c, logic taken);
    return taken ? (c == BP_ST ? BP_ST : bp_ctr_t'(c + 2'd1))
                 : (c == BP_SNT ? BP_SNT : bp_ctr_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/bp_pht.sv
// bp_pht: 2-bit counter array; in clk/reset, rd_idx, wr_en/wr_idx/wr_taken/wr_force_wt; out rd_ctr
module bp_pht
  import lc3b_types::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bp_ctr_t          rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  input  logic             wr_force_wt
);
  bp_ctr_t ctr_q [ENTRIES];
  assign rd_ctr = ctr_q[rd_idx];
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BP_CTR_RESET;
    else if (wr_en) ctr_q[wr_idx] <= wr_force_wt ? BP_WT : bp_ctr_next(ctr_q[wr_idx], wr_taken);
endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB + PHT; in lookup_pc, upd_*; out predict_take/target; gshare via BP_GSHARE_EN
module branch_predictor_btb
  import lc3b_types::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] lookup_pc,
  output logic        predict_take,
  output logic [15:0] predict_target,
  input  logic        upd_valid,
  input  logic        upd_stall,
  input  logic [15:0] upd_pc,
  input  logic        upd_taken,
  input  logic [15:0] upd_target
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 15 - IDX_W;
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [15:0] tgt_q [ENTRIES];
  logic [IDX_W-1:0] lk_idx, up_idx, lk_pidx, up_pidx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic drop_q, drop_d, fire, hit, up_hit, unused_pc0;
  bp_ctr_t rd_ctr;
  assign unused_pc0 = ^{lookup_pc[0], upd_pc[0]};
  assign lk_idx = lookup_pc[IDX_W:1];
  assign lk_tag = lookup_pc[15:IDX_W+1];
  assign up_idx = upd_pc[IDX_W:1];
  assign up_tag = upd_pc[15:IDX_W+1];
  assign hit = !reset && valid_q[lk_idx] && tag_q[lk_idx] == lk_tag;
  assign up_hit = valid_q[up_idx] && tag_q[up_idx] == up_tag;
  assign predict_take = hit && rd_ctr[1];
  assign predict_target = hit ? tgt_q[lk_idx] : 16'h0000;
  // a reset landing on a stalled update kills it until the stall releases
  assign drop_d = (reset && upd_valid && upd_stall) || (drop_q && upd_stall);
  assign fire = upd_valid && !upd_stall && !reset && !drop_q;
  always_ff @(posedge clk) begin
    drop_q <= drop_d;
    if (reset) valid_q <= '0;
    else if (fire && upd_taken) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target;
    end
  end
`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  always_ff @(posedge clk) ghr_q <= reset ? '0 : fire ? {ghr_q[IDX_W-2:0], upd_taken} : ghr_q;
  assign lk_pidx = lk_idx ^ ghr_q;
  assign up_pidx = up_idx ^ ghr_q;
`else
  assign lk_pidx = lk_idx;
  assign up_pidx = up_idx;
`endif
  bp_pht #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_pht (
    .clk(clk), .reset(reset), .rd_idx(lk_pidx), .rd_ctr(rd_ctr), .wr_en(fire),
    .wr_idx(up_pidx), .wr_taken(upd_taken), .wr_force_wt(!up_hit && upd_taken)
  );
endmodule
